// File: rtl/ram_port_arbiter.sv
// Two-client arbiter in front of a 1W/1R synchronous RAM. Each RAM port has its own round-robin pointer.
// Read data returns to its owner one cycle after the grant. Define RAM_ARB_FWD_EN to forward same-address write data.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_wr,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_wr,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  logic a_wr_req, b_wr_req, a_rd_req, b_rd_req;
  logic wr_gnt_a, wr_gnt_b, rd_gnt_a, rd_gnt_b;
  logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic rd_pend_q, rd_pend_d, rd_owner_q, rd_owner_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic [DATA_WIDTH-1:0] ret_data;

  // Pointer value 0 favours A, 1 favours B; the pointer only matters when both want the same port.
  always_comb begin
    a_wr_req = a_req & a_wr & ~rst;
    b_wr_req = b_req & b_wr & ~rst;
    a_rd_req = a_req & ~a_wr & ~rst;
    b_rd_req = b_req & ~b_wr & ~rst;

    wr_gnt_a = a_wr_req & (~b_wr_req | ~wr_ptr_q);
    wr_gnt_b = b_wr_req & (~a_wr_req | wr_ptr_q);
    rd_gnt_a = a_rd_req & (~b_rd_req | ~rd_ptr_q);
    rd_gnt_b = b_rd_req & (~a_rd_req | rd_ptr_q);

    a_gnt = wr_gnt_a | rd_gnt_a;
    b_gnt = wr_gnt_b | rd_gnt_b;

    ram_we      = wr_gnt_a | wr_gnt_b;
    ram_wr_addr = wr_gnt_a ? a_addr  : (wr_gnt_b ? b_addr  : '0);
    ram_data_in = wr_gnt_a ? a_wdata : (wr_gnt_b ? b_wdata : '0);
    ram_re      = rd_gnt_a | rd_gnt_b;
    ram_rd_addr = rd_gnt_a ? a_addr  : (rd_gnt_b ? b_addr  : '0);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (wr_gnt_a)      wr_ptr_d = 1'b1;
    else if (wr_gnt_b) wr_ptr_d = 1'b0;

    rd_ptr_d = rd_ptr_q;
    if (rd_gnt_a)      rd_ptr_d = 1'b1;
    else if (rd_gnt_b) rd_ptr_d = 1'b0;

    rd_pend_d  = ram_re;
    rd_owner_d = rd_gnt_b;
  end

`ifdef RAM_ARB_FWD_EN
  logic                  fwd_valid_q, fwd_valid_d;
  logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;

  // A same-address write in the read's grant cycle supersedes the RAM's old-data return.
  always_comb begin
    fwd_valid_d = ram_we & ram_re & (ram_wr_addr == ram_rd_addr);
    fwd_data_d  = ram_data_in;
    ret_data    = fwd_valid_q ? fwd_data_q : ram_data_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_valid_q <= 1'b0;
      fwd_data_q  <= '0;
    end else begin
      fwd_valid_q <= fwd_valid_d;
      fwd_data_q  <= fwd_data_d;
    end
  end
`else
  always_comb begin
    ret_data = ram_data_out;
  end
`endif

  // rdata follows the RAM in the return cycle and otherwise replays the last returned word.
  always_comb begin
    a_rvalid  = rd_pend_q & ~rd_owner_q;
    b_rvalid  = rd_pend_q & rd_owner_q;
    a_rdata   = a_rvalid ? ret_data : a_rdata_q;
    b_rdata   = b_rvalid ? ret_data : b_rdata_q;
    a_rdata_d = a_rdata;
    b_rdata_d = b_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed vector table plus randomized traffic against a
// transaction-level reference model. Honours RAM_ARB_FWD_EN when defined.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic a_req, a_wr, b_req, b_wr;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
  logic a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic ram_we, ram_re;
  logic [7:0] ram_wr_addr, ram_data_in, ram_rd_addr;
  logic [7:0] ram_data_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_wr_addr(ram_wr_addr), .ram_data_in(ram_data_in),
    .ram_re(ram_re), .ram_rd_addr(ram_rd_addr), .ram_data_out(ram_data_out)
  );

  // Behavioural RAM: registered read, read-before-write on the same address.
  logic [7:0] ram_mem [256];
  initial begin
    for (int i = 0; i < 256; i++) ram_mem[i] = 8'h00;
    ram_data_out = 8'h00;
  end
  always @(posedge clk) begin
    if (ram_re) ram_data_out <= ram_mem[ram_rd_addr];
    if (ram_we) ram_mem[ram_wr_addr] <= ram_data_in;
  end

  // Reference model state: transaction view of memory, pointers and the one outstanding return.
  logic [7:0] ref_mem [256];
  int m_wr_ptr, m_rd_ptr;
  bit ret_v;
  int ret_own;
  logic [7:0] ret_data, hold_a, hold_b;
  bit last_a_gnt, last_b_gnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset_state();
    m_wr_ptr = 0; m_rd_ptr = 0; ret_v = 0; ret_own = 0; ret_data = 0;
    hold_a = 0; hold_b = 0;
  endtask

  // Called at the negedge with inputs settled: compare every output, then advance the model one edge.
  task automatic model_step();
    int wwin, rwin;
    bit aw, bw, ar, br;
    logic [7:0] wa, wd, ra, ea, eb;
    bit eav, ebv;
    aw = a_req && a_wr;  bw = b_req && b_wr;
    ar = a_req && !a_wr; br = b_req && !b_wr;
    wwin = -1; rwin = -1;
    if (!rst) begin
      if (aw && bw) wwin = m_wr_ptr; else if (aw) wwin = 0; else if (bw) wwin = 1;
      if (ar && br) rwin = m_rd_ptr; else if (ar) rwin = 0; else if (br) rwin = 1;
    end
    wa = (wwin == 0) ? a_addr : (wwin == 1) ? b_addr : 8'h00;
    wd = (wwin == 0) ? a_wdata : (wwin == 1) ? b_wdata : 8'h00;
    ra = (rwin == 0) ? a_addr : (rwin == 1) ? b_addr : 8'h00;
    eav = ret_v && ret_own == 0;
    ebv = ret_v && ret_own == 1;
    ea = eav ? ret_data : hold_a;
    eb = ebv ? ret_data : hold_b;

    check("a_gnt", a_gnt, (wwin == 0) || (rwin == 0));
    check("b_gnt", b_gnt, (wwin == 1) || (rwin == 1));
    check("ram_we", ram_we, wwin >= 0);
    check("ram_re", ram_re, rwin >= 0);
    check("ram_wr_addr", ram_wr_addr, wa);
    check("ram_data_in", ram_data_in, wd);
    check("ram_rd_addr", ram_rd_addr, ra);
    check("a_rvalid", a_rvalid, eav);
    check("b_rvalid", b_rvalid, ebv);
    check("a_rdata", a_rdata, ea);
    check("b_rdata", b_rdata, eb);

    last_a_gnt = (wwin == 0) || (rwin == 0);
    last_b_gnt = (wwin == 1) || (rwin == 1);
    if (rst) begin
      model_reset_state();
    end else begin
      hold_a = ea; hold_b = eb;
      ret_v = rwin >= 0;
      if (ret_v) begin
        ret_own  = rwin;
        ret_data = ref_mem[ra];
`ifdef RAM_ARB_FWD_EN
        if (wwin >= 0 && wa == ra) ret_data = wd;
`endif
        m_rd_ptr = 1 - rwin;
      end
      if (wwin >= 0) begin
        ref_mem[wa] = wd;
        m_wr_ptr = 1 - wwin;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit rst;
    bit a_req; bit a_wr; logic [7:0] a_addr; logic [7:0] a_wdata;
    bit b_req; bit b_wr; logic [7:0] b_addr; logic [7:0] b_wdata;
    bit a_gnt; bit b_gnt; bit a_rv; bit b_rv; logic [7:0] a_rd; logic [7:0] b_rd;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit r, input bit ar, input bit aw, input logic [7:0] aa, input logic [7:0] ad,
                     input bit br, input bit bw, input logic [7:0] ba, input logic [7:0] bd,
                     input bit ag, input bit bg, input bit arv, input bit brv,
                     input logic [7:0] ard, input logic [7:0] brd);
    vec_t v;
    v.rst = r; v.a_req = ar; v.a_wr = aw; v.a_addr = aa; v.a_wdata = ad;
    v.b_req = br; v.b_wr = bw; v.b_addr = ba; v.b_wdata = bd;
    v.a_gnt = ag; v.b_gnt = bg; v.a_rv = arv; v.b_rv = brv; v.a_rd = ard; v.b_rd = brd;
    vecs.push_back(v);
  endtask

  task automatic apply_inputs(input bit r, input bit ar, input bit aw, input logic [7:0] aa,
                              input logic [7:0] ad, input bit br, input bit bw,
                              input logic [7:0] ba, input logic [7:0] bd);
    rst = r; a_req = ar; a_wr = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_wr = bw; b_addr = ba; b_wdata = bd;
  endtask

  logic [7:0] coll;
  bit ap, bp;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    model_reset_state();
`ifdef RAM_ARB_FWD_EN
    coll = 8'h3C;
`else
    coll = 8'h00;
`endif
    //   rst A:req wr addr data   B:req wr addr data   gA gB rvA rvB rdA rdB
    add(0, 1,0,8'd5,8'h00,  0,0,8'd0,8'h00,  1,0,0,0,8'h00,8'h00);
    add(0, 0,0,8'd0,8'h00,  1,1,8'd7,8'h11,  0,1,1,0,8'h00,8'h00);
    add(0, 1,1,8'd3,8'h5A,  1,0,8'd7,8'h00,  1,1,0,0,8'h00,8'h00);
    add(0, 1,0,8'd3,8'h00,  0,0,8'd0,8'h00,  1,0,0,1,8'h00,8'h11);
    add(0, 0,0,8'd0,8'h00,  0,0,8'd0,8'h00,  0,0,1,0,8'h5A,8'h11);
    add(1, 0,0,8'd0,8'h00,  0,0,8'd0,8'h00,  0,0,0,0,8'h5A,8'h11);
    add(0, 1,1,8'd1,8'hAA,  1,1,8'd2,8'hBB,  1,0,0,0,8'h00,8'h00);
    add(0, 1,1,8'd1,8'hAA,  1,1,8'd2,8'hBB,  0,1,0,0,8'h00,8'h00);
    add(0, 1,1,8'd1,8'hAA,  1,1,8'd2,8'hBB,  1,0,0,0,8'h00,8'h00);
    add(0, 1,1,8'd1,8'hAA,  1,1,8'd2,8'hBB,  0,1,0,0,8'h00,8'h00);
    add(0, 1,0,8'd1,8'h00,  1,0,8'd2,8'h00,  1,0,0,0,8'h00,8'h00);
    add(0, 1,0,8'd1,8'h00,  1,0,8'd2,8'h00,  0,1,1,0,8'hAA,8'h00);
    add(0, 1,0,8'd1,8'h00,  1,0,8'd2,8'h00,  1,0,0,1,8'hAA,8'hBB);
    add(0, 1,0,8'd1,8'h00,  1,0,8'd2,8'h00,  0,1,1,0,8'hAA,8'hBB);
    add(0, 0,0,8'd0,8'h00,  0,0,8'd0,8'h00,  0,0,0,1,8'hAA,8'hBB);
    add(0, 1,1,8'd9,8'h3C,  1,0,8'd9,8'h00,  1,1,0,0,8'hAA,8'hBB);
    add(0, 1,0,8'd9,8'h00,  0,0,8'd0,8'h00,  1,0,0,1,8'hAA,coll);
    add(0, 0,0,8'd0,8'h00,  0,0,8'd0,8'h00,  0,0,1,0,8'h3C,coll);
    add(1, 1,0,8'd5,8'h00,  0,0,8'd0,8'h00,  0,0,0,0,8'h3C,coll);
    add(0, 0,0,8'd0,8'h00,  0,0,8'd0,8'h00,  0,0,0,0,8'h00,8'h00);
    add(0, 1,0,8'd1,8'h00,  1,0,8'd2,8'h00,  1,0,0,0,8'h00,8'h00);
    add(0, 1,1,8'd1,8'h55,  1,1,8'd2,8'h66,  1,0,1,0,8'hAA,8'h00);

    apply_inputs(1, 0,0,8'd0,8'd0, 0,0,8'd0,8'd0);
    repeat (2) tick();

    foreach (vecs[i]) begin
      apply_inputs(vecs[i].rst, vecs[i].a_req, vecs[i].a_wr, vecs[i].a_addr, vecs[i].a_wdata,
                   vecs[i].b_req, vecs[i].b_wr, vecs[i].b_addr, vecs[i].b_wdata);
      @(negedge clk);
      check($sformatf("vec%0d_a_gnt", i), a_gnt, vecs[i].a_gnt);
      check($sformatf("vec%0d_b_gnt", i), b_gnt, vecs[i].b_gnt);
      check($sformatf("vec%0d_a_rvalid", i), a_rvalid, vecs[i].a_rv);
      check($sformatf("vec%0d_b_rvalid", i), b_rvalid, vecs[i].b_rv);
      check($sformatf("vec%0d_a_rdata", i), a_rdata, vecs[i].a_rd);
      check($sformatf("vec%0d_b_rdata", i), b_rdata, vecs[i].b_rd);
      model_step();
      @(posedge clk);
      #1;
    end

    // Randomized traffic: each client holds its request until granted, small address range for collisions.
    ap = 0; bp = 0;
    apply_inputs(0, 0,0,8'd0,8'd0, 0,0,8'd0,8'd0);
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!ap && $urandom_range(0, 3) != 0) begin
        ap = 1; a_wr = $urandom_range(0, 1); a_addr = 8'($urandom_range(0, 15)); a_wdata = 8'($urandom);
      end
      if (!bp && $urandom_range(0, 3) != 0) begin
        bp = 1; b_wr = $urandom_range(0, 1); b_addr = 8'($urandom_range(0, 15)); b_wdata = 8'($urandom);
      end
      a_req = ap; b_req = bp;
      tick();
      if (last_a_gnt) ap = 0;
      if (last_b_gnt) bp = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
